// File: rtl/dram_pkg.sv
// Shared types and default timing for the FPM DRAM controller.
// Optional build macro: DRAM_REFRESH_DEBT_EN (refresh debt counter instead of a single flag).
package dram_pkg;

   // Default geometry: CPU word address A[21:1] split into row and column.
   localparam int unsigned DEF_ROW_BITS  = 11;
   localparam int unsigned DEF_COL_BITS  = 10;
   localparam int unsigned DEF_ADDR_BITS = DEF_ROW_BITS + DEF_COL_BITS;

   // Row occupies the upper ADDR bits, starting just above the column field.
   localparam int unsigned DEF_ROW_LSB   = DEF_COL_BITS;

   // Default timing in 40 MHz clock cycles.
   localparam int unsigned DEF_RAS_TO_CAS_CYCLES  = 1;
   localparam int unsigned DEF_CAS_CYCLES         = 2;
   localparam int unsigned DEF_PRECHARGE_CYCLES   = 2;
   localparam int unsigned DEF_REFRESH_INTERVAL   = 600;
   localparam int unsigned DEF_REFRESH_RAS_CYCLES = 3;

   // Width of the shared per-state cycle counter.
   localparam int unsigned CNT_BITS = 8;

   typedef enum logic [2:0] {
      StIdle,
      StRow,
      StCol,
      StCas,
      StAck,
      StPre,
      StRefCas,
      StRefRas
   } dram_state_e;

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval counter plus the pending-refresh record.
// Optional build macro: DRAM_REFRESH_DEBT_EN keeps a 3-bit saturating debt instead of one flag.
module dram_refresh_timer
   import dram_pkg::*;
#(
   parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
   input  logic CLK,
   input  logic RST,
   input  logic take,
   output logic pending
);

   localparam int unsigned TW = $clog2(REFRESH_INTERVAL);
   localparam logic [TW-1:0] LAST = TW'(REFRESH_INTERVAL - 1);

   logic [TW-1:0] cnt_q;
   logic          tick;

   assign tick = (cnt_q == LAST);

   // Free-running interval counter, wraps at REFRESH_INTERVAL-1 in every FSM state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + TW'(1);
      end
   end

`ifdef DRAM_REFRESH_DEBT_EN
   logic [2:0] debt_q;

   // Saturating debt: tick adds one, take removes one, both together cancel.
   always_ff @(posedge CLK) begin
      if (RST) begin
         debt_q <= 3'd0;
      end else if (tick && !take && (debt_q != 3'd7)) begin
         debt_q <= debt_q + 3'd1;
      end else if (take && !tick && (debt_q != 3'd0)) begin
         debt_q <= debt_q - 3'd1;
      end
   end

   assign pending = (debt_q != 3'd0);
`else
   logic pending_q;

   // Single flag: a tick while already pending is lost; tick with take keeps it set.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pending_q <= 1'b0;
      end else if (tick) begin
         pending_q <= 1'b1;
      end else if (take) begin
         pending_q <= 1'b0;
      end
   end

   assign pending = pending_q;
`endif

endmodule

// File: rtl/dram_controller.sv
// FPM DRAM sequencer for the 68000 bus: row/column mux, RAS/CAS/WE, DTACK and CBR refresh.
// Optional build macro: DRAM_REFRESH_DEBT_EN (back-to-back refreshes to pay accumulated debt).
module dram_controller
   import dram_pkg::*;
#(
   parameter int unsigned ROW_BITS           = DEF_ROW_BITS,
   parameter int unsigned COL_BITS           = DEF_COL_BITS,
   parameter int unsigned RAS_TO_CAS_CYCLES  = DEF_RAS_TO_CAS_CYCLES,
   parameter int unsigned CAS_CYCLES         = DEF_CAS_CYCLES,
   parameter int unsigned PRECHARGE_CYCLES   = DEF_PRECHARGE_CYCLES,
   parameter int unsigned REFRESH_INTERVAL   = DEF_REFRESH_INTERVAL,
   parameter int unsigned REFRESH_RAS_CYCLES = DEF_REFRESH_RAS_CYCLES
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [ROW_BITS+COL_BITS-1:0] ADDR,
   input  logic                         AS_n,
   input  logic                         UDS_n,
   input  logic                         LDS_n,
   input  logic                         RW,
   input  logic                         CS_DRAM_n,
   output logic [ROW_BITS-1:0]          DRAM_ADDR,
   output logic                         RAS_n,
   output logic                         CASU_n,
   output logic                         CASL_n,
   output logic                         WE_n,
   output logic                         DTACK_DRAM_n,
   output logic                         REFRESH_BUSY
);

   localparam logic [CNT_BITS-1:0] ROW_LAST = CNT_BITS'(RAS_TO_CAS_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] CAS_LAST = CNT_BITS'(CAS_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] PRE_LAST = CNT_BITS'(PRECHARGE_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] REF_LAST = CNT_BITS'(REFRESH_RAS_CYCLES - 1);

   dram_state_e         state_q;
   logic [CNT_BITS-1:0] cnt_q;
   logic [ROW_BITS-1:0] dram_addr_q;
   logic                ras_n_q;
   logic                casu_n_q;
   logic                casl_n_q;
   logic                we_n_q;
   logic                dtack_n_q;
   logic                busy_q;

   logic                req;
   logic                refresh_pending;
   logic                refresh_take;
   logic [ROW_BITS-1:0] row_addr;
   logic [ROW_BITS-1:0] col_addr;

   assign req          = ~AS_n & ~CS_DRAM_n;
   assign row_addr     = ADDR[ROW_BITS+COL_BITS-1 -: ROW_BITS];
   assign col_addr     = ROW_BITS'(ADDR[COL_BITS-1:0]);
   // Refresh is consumed on the same edge IDLE launches REF_CAS.
   assign refresh_take = (state_q == StIdle) && refresh_pending;

   dram_refresh_timer #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL)
   ) u_refresh_timer (
      .CLK     (CLK),
      .RST     (RST),
      .take    (refresh_take),
      .pending (refresh_pending)
   );

   // Main sequencer; every DRAM pin and DTACK is a register written here.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         dram_addr_q <= '0;
         ras_n_q     <= 1'b1;
         casu_n_q    <= 1'b1;
         casl_n_q    <= 1'b1;
         we_n_q      <= 1'b1;
         dtack_n_q   <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               dram_addr_q <= row_addr;
               cnt_q       <= '0;
               if (refresh_pending) begin
                  casu_n_q <= 1'b0;
                  casl_n_q <= 1'b0;
                  we_n_q   <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= StRefCas;
               end else if (req) begin
                  ras_n_q <= 1'b0;
                  state_q <= StRow;
               end
            end

            StRow: begin
               if (AS_n) begin
                  ras_n_q   <= 1'b1;
                  casu_n_q  <= 1'b1;
                  casl_n_q  <= 1'b1;
                  we_n_q    <= 1'b1;
                  dtack_n_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= StPre;
               end else if (cnt_q == ROW_LAST) begin
                  dram_addr_q <= col_addr;
                  we_n_q      <= RW;
                  cnt_q       <= '0;
                  state_q     <= StCol;
               end else begin
                  cnt_q <= cnt_q + CNT_BITS'(1);
               end
            end

            StCol: begin
               if (AS_n) begin
                  ras_n_q   <= 1'b1;
                  casu_n_q  <= 1'b1;
                  casl_n_q  <= 1'b1;
                  we_n_q    <= 1'b1;
                  dtack_n_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= StPre;
               end else if (RW || !UDS_n || !LDS_n) begin
                  // Write data strobes trail AS_n by a CPU cycle, so wait for them here.
                  casu_n_q <= UDS_n;
                  casl_n_q <= LDS_n;
                  cnt_q    <= '0;
                  state_q  <= StCas;
               end
            end

            StCas: begin
               if (AS_n) begin
                  ras_n_q   <= 1'b1;
                  casu_n_q  <= 1'b1;
                  casl_n_q  <= 1'b1;
                  we_n_q    <= 1'b1;
                  dtack_n_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= StPre;
               end else if (cnt_q == CAS_LAST) begin
                  dtack_n_q <= 1'b0;
                  state_q   <= StAck;
               end else begin
                  cnt_q <= cnt_q + CNT_BITS'(1);
               end
            end

            StAck: begin
               if (AS_n) begin
                  ras_n_q   <= 1'b1;
                  casu_n_q  <= 1'b1;
                  casl_n_q  <= 1'b1;
                  we_n_q    <= 1'b1;
                  dtack_n_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= StPre;
               end
            end

            StPre: begin
               if (cnt_q == PRE_LAST) begin
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CNT_BITS'(1);
               end
            end

            StRefCas: begin
               // CAS-before-RAS: CAS already low, now drop RAS.
               ras_n_q <= 1'b0;
               cnt_q   <= '0;
               state_q <= StRefRas;
            end

            StRefRas: begin
               if (cnt_q == REF_LAST) begin
                  ras_n_q  <= 1'b1;
                  casu_n_q <= 1'b1;
                  casl_n_q <= 1'b1;
                  we_n_q   <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= StPre;
               end else begin
                  cnt_q <= cnt_q + CNT_BITS'(1);
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign DRAM_ADDR    = dram_addr_q;
   assign RAS_n        = ras_n_q;
   assign CASU_n       = casu_n_q;
   assign CASL_n       = casl_n_q;
   assign WE_n         = we_n_q;
   assign DTACK_DRAM_n = dtack_n_q;
   assign REFRESH_BUSY = busy_q;

endmodule

// File: tb/tb_dram_controller.sv
// Directed self-checking bench for dram_controller.
// Strobe vector below is {RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n}.
module tb_dram_controller;

   logic        CLK = 1'b0;
   logic        RST;
   logic [20:0] ADDR;
   logic        AS_n;
   logic        UDS_n;
   logic        LDS_n;
   logic        RW;
   logic        CS_DRAM_n;
   logic [10:0] DRAM_ADDR;
   logic        RAS_n;
   logic        CASU_n;
   logic        CASL_n;
   logic        WE_n;
   logic        DTACK_DRAM_n;
   logic        REFRESH_BUSY;
   logic [4:0]  strb;

   int n_cmp  = 0;
   int n_err  = 0;
   int edge_n = 0;

   assign strb = {RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n};

   dram_controller dut (
      .CLK          (CLK),
      .RST          (RST),
      .ADDR         (ADDR),
      .AS_n         (AS_n),
      .UDS_n        (UDS_n),
      .LDS_n        (LDS_n),
      .RW           (RW),
      .CS_DRAM_n    (CS_DRAM_n),
      .DRAM_ADDR    (DRAM_ADDR),
      .RAS_n        (RAS_n),
      .CASU_n       (CASU_n),
      .CASL_n       (CASL_n),
      .WE_n         (WE_n),
      .DTACK_DRAM_n (DTACK_DRAM_n),
      .REFRESH_BUSY (REFRESH_BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   // One clock edge, then sample 1 time unit later.
   task automatic step();
      @(posedge CLK);
      #1;
      edge_n++;
   endtask

   task automatic wait_to(input int k);
      while (edge_n < k) step();
   endtask

   task automatic bus_idle();
      AS_n      = 1'b1;
      UDS_n     = 1'b1;
      LDS_n     = 1'b1;
      RW        = 1'b1;
      CS_DRAM_n = 1'b1;
   endtask

   // One reset edge; the refresh counter restarts so edge_n counts from 0 again.
   task automatic do_reset();
      RST  = 1'b1;
      ADDR = '0;
      bus_idle();
      @(posedge CLK);
      #1;
      chk("rst_strb", 32'(strb), 32'h1F);
      chk("rst_addr", 32'(DRAM_ADDR), 32'h0);
      chk("rst_busy", 32'(REFRESH_BUSY), 32'h0);
      RST    = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      // Word read at 0x0A5A5: row 0x029, col 0x1A5.
      do_reset();
      ADDR = 21'h0A5A5; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; RW = 1'b1; CS_DRAM_n = 1'b0;
      step();
      chk("rd_e0_strb", 32'(strb), 32'h0F);
      chk("rd_e0_row", 32'(DRAM_ADDR), 32'h029);
      step();
      chk("rd_e1_strb", 32'(strb), 32'h0F);
      chk("rd_e1_col", 32'(DRAM_ADDR), 32'h1A5);
      step();
      chk("rd_e2_cas", 32'(strb), 32'h03);
      step();
      chk("rd_e3_cas", 32'(strb), 32'h03);
      step();
      chk("rd_e4_dtack", 32'(strb), 32'h02);
      step();
      step();
      chk("rd_ack_hold", 32'(strb), 32'h02);
      bus_idle();
      step();
      chk("rd_release", 32'(strb), 32'h1F);
      chk("rd_release_busy", 32'(REFRESH_BUSY), 32'h0);
      step();
      chk("rd_pre", 32'(strb), 32'h1F);
      step();
      step();
      chk("rd_idle_row", 32'(DRAM_ADDR), 32'h029);

      // Byte write at 0x12345 (row 0x048, col 0x345); LDS_n arrives late.
      do_reset();
      ADDR = 21'h12345; AS_n = 1'b0; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b0; CS_DRAM_n = 1'b0;
      step();
      chk("wr_e0_strb", 32'(strb), 32'h0F);
      chk("wr_e0_row", 32'(DRAM_ADDR), 32'h048);
      step();
      chk("wr_e1_strb", 32'(strb), 32'h0D);
      chk("wr_e1_col", 32'(DRAM_ADDR), 32'h345);
      step();
      chk("wr_col_wait", 32'(strb), 32'h0D);
      LDS_n = 1'b0;
      step();
      chk("wr_casl", 32'(strb), 32'h09);
      step();
      chk("wr_casl_hold", 32'(strb), 32'h09);
      step();
      chk("wr_dtack", 32'(strb), 32'h08);
      bus_idle();
      step();
      chk("wr_release", 32'(strb), 32'h1F);

      // Idle refresh: tick at edge 600, REF_CAS at 601, RAS low 602..604, PRE 605..606.
      do_reset();
      wait_to(600);
      chk("ref_before", 32'(strb), 32'h1F);
      chk("ref_before_busy", 32'(REFRESH_BUSY), 32'h0);
      step();
      chk("ref_cas", 32'(strb), 32'h13);
      chk("ref_cas_busy", 32'(REFRESH_BUSY), 32'h1);
      step();
      chk("ref_ras_first", 32'(strb), 32'h03);
      chk("ref_ras_busy", 32'(REFRESH_BUSY), 32'h1);
      wait_to(604);
      chk("ref_ras_last", 32'(strb), 32'h03);
      step();
      chk("ref_pre", 32'(strb), 32'h1F);
      chk("ref_pre_busy", 32'(REFRESH_BUSY), 32'h1);
      step();
      chk("ref_pre2_busy", 32'(REFRESH_BUSY), 32'h1);
      step();
      chk("ref_done_busy", 32'(REFRESH_BUSY), 32'h0);
      chk("ref_done_strb", 32'(strb), 32'h1F);

      // Request first seen on the same IDLE edge as a pending refresh: refresh goes first.
      do_reset();
      wait_to(600);
      ADDR = 21'h0A5A5; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; RW = 1'b1; CS_DRAM_n = 1'b0;
      step();
      chk("tie_refcas", 32'(strb), 32'h13);
      wait_to(606);
      chk("tie_pre", 32'(strb), 32'h1F);
      step();
      chk("tie_idle", 32'(strb), 32'h1F);
      step();
      chk("tie_ras", 32'(strb), 32'h0F);
      chk("tie_row", 32'(DRAM_ADDR), 32'h029);
      wait_to(611);
      chk("tie_no_dtack", 32'(strb), 32'h03);
      step();
      chk("tie_dtack", 32'(strb), 32'h02);
      bus_idle();
      step();
      chk("tie_release", 32'(strb), 32'h1F);

      // Abort in COL, then a request during PRE is served from IDLE.
      do_reset();
      ADDR = 21'h12345; AS_n = 1'b0; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b0; CS_DRAM_n = 1'b0;
      step();
      step();
      chk("ab_col", 32'(strb), 32'h0D);
      AS_n = 1'b1;
      step();
      chk("ab_release", 32'(strb), 32'h1F);
      ADDR = 21'h0A5A5; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; RW = 1'b1;
      step();
      chk("ab_pre_req1", 32'(strb), 32'h1F);
      step();
      chk("ab_pre_req2", 32'(strb), 32'h1F);
      step();
      chk("ab_new_ras", 32'(strb), 32'h0F);
      chk("ab_new_row", 32'(DRAM_ADDR), 32'h029);
      bus_idle();
      step();
      chk("ab_row_abort", 32'(strb), 32'h1F);

      // Reset in the middle of REF_RAS.
      do_reset();
      wait_to(603);
      chk("mid_ref_ras", 32'(strb), 32'h03);
      RST = 1'b1;
      step();
      chk("mid_rst_strb", 32'(strb), 32'h1F);
      chk("mid_rst_addr", 32'(DRAM_ADDR), 32'h0);
      chk("mid_rst_busy", 32'(REFRESH_BUSY), 32'h0);
      RST    = 1'b0;
      edge_n = 0;
      step();
      chk("mid_after_strb", 32'(strb), 32'h1F);
      chk("mid_after_busy", 32'(REFRESH_BUSY), 32'h0);

      // Access held in ACK across ticks at 600/1200/1800, released after edge 2005.
      do_reset();
      ADDR = 21'h0A5A5; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; RW = 1'b1; CS_DRAM_n = 1'b0;
      wait_to(5);
      chk("debt_ack", 32'(strb), 32'h02);
      wait_to(2005);
      chk("debt_ack_long", 32'(strb), 32'h02);
      bus_idle();
      step();
      chk("debt_release", 32'(strb), 32'h1F);
      wait_to(2009);
      chk("debt_ref1", 32'(strb), 32'h13);
`ifdef DRAM_REFRESH_DEBT_EN
      wait_to(2016);
      chk("debt_ref2", 32'(strb), 32'h13);
      wait_to(2023);
      chk("debt_ref3", 32'(strb), 32'h13);
      wait_to(2030);
      chk("debt_none4", 32'(strb), 32'h1F);
      chk("debt_none4_busy", 32'(REFRESH_BUSY), 32'h0);
`else
      wait_to(2016);
      chk("flag_no_ref2", 32'(strb), 32'h1F);
      chk("flag_no_ref2_busy", 32'(REFRESH_BUSY), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dram_controller.md
Name: dram_controller

Overview:
- Sequences the 16-bit FPM DRAM array in the 0x100000–0xEFFFFF window behind the 68000 bus.
- Multiplexes row and column addresses, drives RAS_n/CASU_n/CASL_n/WE_n, and returns DTACK_DRAM_n to the system controller.
- Arbitrates the array between CPU accesses and periodic CAS-before-RAS refresh.
- Runs on the 40 MHz oscillator clock. The CPU clock is derived from it at /2, so bus inputs are sampled directly without synchronisers.

Parameters:
- ROW_BITS, 11, row address width; also the DRAM_ADDR width.
- COL_BITS, 10, column address width; zero-extended to ROW_BITS on DRAM_ADDR.
- RAS_TO_CAS_CYCLES, 1, cycles RAS_n is low with the row address before switching to column.
- CAS_CYCLES, 2, cycles CAS is low before DTACK_DRAM_n asserts.
- PRECHARGE_CYCLES, 2, cycles with all strobes high after any cycle.
- REFRESH_INTERVAL, 600, CLK cycles between refresh requests (15 us at 40 MHz).
- REFRESH_RAS_CYCLES, 3, RAS low time during refresh.

Ports:
- CLK  in  1  40 MHz oscillator clock
- RST  in  1  synchronous reset, active-high
- ADDR  in  ROW_BITS+COL_BITS  CPU word address A[21:1]; row = upper ROW_BITS, col = lower COL_BITS
- AS_n  in  1  CPU address strobe
- UDS_n  in  1  CPU upper data strobe
- LDS_n  in  1  CPU lower data strobe
- RW  in  1  CPU read(1)/write(0)
- CS_DRAM_n  in  1  decode from system controller
- DRAM_ADDR  out  ROW_BITS  multiplexed row/column address
- RAS_n  out  1  row strobe
- CASU_n  out  1  upper-byte column strobe
- CASL_n  out  1  lower-byte column strobe
- WE_n  out  1  DRAM write enable
- DTACK_DRAM_n  out  1  transfer acknowledge to the system controller
- REFRESH_BUSY  out  1  high in REF_CAS, REF_RAS, and the PRE that follows them (debug/LED)

Behaviour:
- Timing and reset:
  - All outputs are registered.
  - Reset (sync, any state, mid-cycle included) values: RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n = 1; DRAM_ADDR = 0; REFRESH_BUSY = 0.
  - Reset also sets state = IDLE, refresh counter = 0, pending = 0.
- Refresh timer:
  - Counts 0..REFRESH_INTERVAL-1 and wraps.
  - On the wrap it sets refresh_pending.
  - Counting continues in every state.
- Access request: req = ~AS_n & ~CS_DRAM_n.
- State machine:
  - IDLE:
    - DRAM_ADDR <= row(ADDR) every cycle.
    - If refresh_pending → REF_CAS. Refresh wins ties with req.
    - Else if req → ROW, with RAS_n <= 0.
  - ROW:
    - Hold RAS_n = 0 for RAS_TO_CAS_CYCLES.
    - Then DRAM_ADDR <= col(ADDR) and WE_n <= RW → COL.
  - COL:
    - Wait until RW=1, or UDS_n=0, or LDS_n=0. Write strobes arrive one CPU cycle late.
    - Then CASU_n <= UDS_n and CASL_n <= LDS_n → CAS.
  - CAS:
    - After CAS_CYCLES, DTACK_DRAM_n <= 0 → ACK.
  - ACK:
    - Hold all strobes and DTACK until AS_n is sampled high.
    - Then all strobes, WE_n, and DTACK <= 1 → PRE.
  - PRE:
    - All strobes high for PRECHARGE_CYCLES → IDLE.
  - REF_CAS:
    - CASU_n = CASL_n = 0 and WE_n = 1 for one cycle.
    - Then RAS_n <= 0 → REF_RAS.
    - Clear one pending request on entry.
  - REF_RAS:
    - Hold RAS low for REFRESH_RAS_CYCLES.
    - Then all strobes high → PRE.
- Default read latency: RAS falls on edge 0. Column address at edge 1, CAS at edge 2, DTACK at edge 4 (100 ns).
- Boundary conditions:
  - AS_n rising in ROW, COL, or CAS (bus error or abort): next edge all strobes and DTACK high → PRE.
  - req during refresh or PRE: no strobes, DTACK held high; the request is serviced from IDLE.
  - A refresh tick during an access only sets pending; it never interrupts an access.
  - A tick while pending is already set is dropped (base build).
  - DTACK_DRAM_n is never low outside ACK.
  - RAS_n and CAS are never both toggled on the same edge except the documented transitions.

Optional Feature:
- Macro: DRAM_REFRESH_DEBT_EN.
- Defined:
  - refresh_pending becomes a 3-bit saturating debt counter (max 7).
  - Each tick increments it; each REF_CAS entry decrements it.
  - IDLE performs back-to-back refreshes while debt > 0.
  - A tick and a decrement on the same edge leave it unchanged.
- Undefined: single pending flag as above; extra ticks are lost.

Decomposition:
- Package dram_pkg:
  - State enum: IDLE, ROW, COL, CAS, ACK, PRE, REF_CAS, REF_RAS.
  - Default timing constants.
  - Row/column slice helper constants.
- Sub-module dram_refresh_timer: the interval counter plus the pending flag or debt counter, with a tick-consume handshake from the main FSM.

Test Plan:
- Reset then word read at ADDR=0x0A5A5 (AS_n, UDS_n, LDS_n low, RW=1):
  - Row 0x029 driven with RAS fall at edge 0.
  - Col 0x1A5 at edge 1, both CAS low at edge 2, DTACK_DRAM_n low at edge 4.
  - All high one edge after AS_n rises.
- Byte write, LDS_n low two cycles after AS_n, RW=0: FSM waits in COL; only CASL_n falls, WE_n=0, DTACK after CAS_CYCLES.
- Idle 600 cycles: REF_CAS one cycle with both CAS low and RAS high, then RAS low 3 cycles, then PRE 2 cycles; REFRESH_BUSY high throughout.
- Request and refresh tick on the same IDLE edge: refresh runs first; CPU DTACK asserts only after PRE plus the 4-edge access latency.
- AS_n deasserted in COL: strobes high next edge, no DTACK; assert RST mid-REF_RAS → all outputs at reset values next edge.
- DRAM_REFRESH_DEBT_EN: hold an access in ACK for 2000 cycles → debt 3; exactly 3 consecutive refreshes follow.
